score_keeper: RTL
=================

Name: score_keeper

Overview:
- Downstream stage of the strum/note judge. Consumes one judgement event per expected-note window (hit or miss) and maintains the player's score, streak, multiplier and health ("rock meter").
- Declares game over when health is exhausted.
- Outputs feed the HEX/VGA display logic and the note scheduler's pause control.

Parameters:
- BASE_POINTS, 50, points per hit before the multiplier is applied
- STREAK_STEP, 10, consecutive hits needed per multiplier increment
- MAX_MULT, 4, multiplier ceiling (at most 7)
- HEALTH_MAX, 20, health ceiling
- HEALTH_START, 10, health loaded at game start (1..HEALTH_MAX)
- MISS_PENALTY, 2, health removed per miss
- SCORE_W, 16, score width

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- start  in  1  level; sampled each cycle, acted on at its rising edge
- judge_valid  in  1  one-cycle pulse: one note window judged
- judge_hit  in  1  qualifies judge_valid: 1 = hit, 0 = miss
- score  out  SCORE_W  accumulated points
- streak  out  8  current consecutive hits
- best_streak  out  8  longest streak this game
- multiplier  out  3  current multiplier, 1..MAX_MULT
- health  out  5  current health, 0..HEALTH_MAX
- playing  out  1  high in PLAYING
- game_over  out  1  high in FAILED

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, score=0, streak=0, best_streak=0, multiplier=1, health=HEALTH_START, playing=0, game_over=0.
  - start edge detector cleared, so a start held high through reset release does not count as an edge.
- Start edge: rising edge of start, detected with one register: prev_start <= start; edge = start & ~prev_start.
- States:
  - IDLE:
    - start edge -> PLAYING.
    - On that same clock: score=0, streak=0, best_streak=0, multiplier=1, health=HEALTH_START.
  - PLAYING:
    - Processes judge_valid as described below.
    - Health reaching 0 -> FAILED.
    - A start edge while PLAYING is ignored.
  - FAILED:
    - All counters frozen; game_over=1.
    - Start edge -> PLAYING, with the same re-initialisation as from IDLE.
- Outputs are registered. Every update is visible on the clock edge after the cycle in which judge_valid is sampled high (latency 1).
- judge_valid in IDLE or FAILED: ignored, no counter changes.
- judge_valid coincident with a start edge in IDLE or FAILED: the start takes effect and the judgement is dropped.
- Hit (judge_valid=1, judge_hit=1, PLAYING):
  - score += BASE_POINTS * multiplier, using the multiplier value before this hit. Saturates at 2^SCORE_W-1; never wraps.
  - streak += 1, saturating at 255.
  - best_streak = max(best_streak, new streak).
  - health += 1, saturating at HEALTH_MAX.
  - multiplier = min(MAX_MULT, 1 + new_streak / STREAK_STEP), computed from the new streak.
- Miss (judge_valid=1, judge_hit=0, PLAYING):
  - streak=0, multiplier=1.
  - health -= MISS_PENALTY, floored at 0.
  - If the resulting health is 0: transition to FAILED on the same edge. playing falls and game_over rises together with the health=0 update.
- judge_valid pulses on consecutive cycles: each is processed independently. There is no back-pressure and no event is lost.
- Multiplier arithmetic:
  - No divider. Keep a 0..STREAK_STEP-1 sub-counter alongside streak.
  - Sub-counter wraps to 0 and multiplier increments (if below MAX_MULT) on the hit that makes streak a multiple of STREAK_STEP.
  - Both are cleared on a miss.
- Product arithmetic:
  - BASE_POINTS*multiplier is computed at SCORE_W+3 bits.
  - Sum is computed at SCORE_W+4 bits, then clamped.

Test Plan:
- Reset, pulse start, then 10 hits -> score=500, streak=10, multiplier=2, health=20 (saturated from 10), game_over=0.
- Continue from there with one more hit -> score=600 (+100, using multiplier 2), streak=11; after 30 total hits multiplier=4, and it stays 4 at 40 hits.
- 12 hits then 1 miss -> streak=0, best_streak=12, multiplier=1, health=18; the next hit adds exactly 50.
- From start with no hits, 5 misses -> health 8, 6, 4, 2, 0. FAILED on the 5th edge, with playing=0 and game_over=1 in the same cycle. Further judge_valid pulses change nothing. A start edge re-initialises all counters to their start values.
- Force score near the ceiling (SCORE_W=8, BASE_POINTS=50, 6 hits) -> score saturates at 255, no wrap. Also hold judge_valid high for 3 consecutive hit cycles -> streak advances by exactly 3.
- Assert resetn low mid-game, asynchronously between clock edges -> outputs return to reset values immediately. A start held high through reset release does not start a game until it falls and rises again.

Source files
------------

// File: rtl/score_keeper.sv
// Score/streak/multiplier/health tracker fed by the note judge.
// One judgement per cycle, all outputs registered with one cycle of latency.
module score_keeper #(
  parameter int BASE_POINTS  = 50,
  parameter int STREAK_STEP  = 10,
  parameter int MAX_MULT     = 4,
  parameter int HEALTH_MAX   = 20,
  parameter int HEALTH_START = 10,
  parameter int MISS_PENALTY = 2,
  parameter int SCORE_W      = 16
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic               judge_valid,
  input  logic               judge_hit,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak,
  output logic [7:0]         best_streak,
  output logic [2:0]         multiplier,
  output logic [4:0]         health,
  output logic               playing,
  output logic               game_over
);

  localparam int SUB_W = (STREAK_STEP > 1) ? $clog2(STREAK_STEP) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_FAILED  = 2'd2;

  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [SUB_W-1:0]   SUB_LAST     = SUB_W'(STREAK_STEP - 1);
  localparam logic [2:0]         MULT_MAX     = 3'(MAX_MULT);
  localparam logic [4:0]         HEALTH_TOP   = 5'(HEALTH_MAX);
  localparam logic [4:0]         HEALTH_INIT  = 5'(HEALTH_START);
  localparam logic [4:0]         PENALTY      = 5'(MISS_PENALTY);

  logic [1:0]         state_reg,  state_next;
  logic               prev_start_reg;
  logic [SCORE_W-1:0] score_reg,  score_next;
  logic [7:0]         streak_reg, streak_next;
  logic [7:0]         best_reg,   best_next;
  logic [2:0]         mult_reg,   mult_next;
  logic [4:0]         health_reg, health_next;
  logic [SUB_W-1:0]   sub_reg,    sub_next;

  logic               start_edge;
  logic [SCORE_W+2:0] product;
  logic [SCORE_W+3:0] sum;
  logic [SCORE_W-1:0] score_hit;
  logic               streak_sat;
  logic [7:0]         streak_inc;
  logic [4:0]         health_hit;
  logic [4:0]         health_miss;

  assign start_edge  = start & ~prev_start_reg;
  assign product     = (SCORE_W+3)'(BASE_POINTS) * (SCORE_W+3)'(mult_reg);
  assign sum         = (SCORE_W+4)'(score_reg) + (SCORE_W+4)'(product);
  assign score_hit   = (sum > (SCORE_W+4)'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
  assign streak_sat  = &streak_reg;
  assign streak_inc  = streak_sat ? streak_reg : streak_reg + 8'd1;
  assign health_hit  = (health_reg >= HEALTH_TOP) ? HEALTH_TOP : health_reg + 5'd1;
  assign health_miss = (health_reg > PENALTY) ? health_reg - PENALTY : 5'd0;

  always_comb begin
    state_next  = state_reg;
    score_next  = score_reg;
    streak_next = streak_reg;
    best_next   = best_reg;
    mult_next   = mult_reg;
    health_next = health_reg;
    sub_next    = sub_reg;
    case (state_reg)
      ST_IDLE, ST_FAILED: begin
        // A start edge wins over any judgement arriving on the same cycle.
        if (start_edge) begin
          state_next  = ST_PLAYING;
          score_next  = '0;
          streak_next = 8'd0;
          best_next   = 8'd0;
          mult_next   = 3'd1;
          health_next = HEALTH_INIT;
          sub_next    = '0;
        end
      end
      ST_PLAYING: begin
        if (judge_valid && judge_hit) begin
          score_next  = score_hit;
          streak_next = streak_inc;
          health_next = health_hit;
          if (streak_inc > best_reg)
            best_next = streak_inc;
          // Sub-counter stops with a saturated streak so the multiplier keeps
          // tracking 1 + streak / STREAK_STEP exactly.
          if (!streak_sat) begin
            if (sub_reg == SUB_LAST) begin
              sub_next = '0;
              if (mult_reg < MULT_MAX)
                mult_next = mult_reg + 3'd1;
            end else begin
              sub_next = sub_reg + SUB_W'(1);
            end
          end
        end else if (judge_valid) begin
          streak_next = 8'd0;
          mult_next   = 3'd1;
          sub_next    = '0;
          health_next = health_miss;
          if (health_miss == 5'd0)
            state_next = ST_FAILED;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      // Preset high so a start already asserted at reset release is not an edge.
      prev_start_reg <= 1'b1;
      score_reg      <= '0;
      streak_reg     <= 8'd0;
      best_reg       <= 8'd0;
      mult_reg       <= 3'd1;
      health_reg     <= HEALTH_INIT;
      sub_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      prev_start_reg <= start;
      score_reg      <= score_next;
      streak_reg     <= streak_next;
      best_reg       <= best_next;
      mult_reg       <= mult_next;
      health_reg     <= health_next;
      sub_reg        <= sub_next;
    end
  end

  assign score       = score_reg;
  assign streak      = streak_reg;
  assign best_streak = best_reg;
  assign multiplier  = mult_reg;
  assign health      = health_reg;
  assign playing     = (state_reg == ST_PLAYING);
  assign game_over   = (state_reg == ST_FAILED);

endmodule
